// File: rtl/snoop_agent.sv
// Cache-side snoop protocol agent: publishes written blocks, resolves misses via the peer, serves peer probes, applies broadcasts.
// Optional miss timeout enabled by defining SNOOP_AGENT_TIMEOUT_EN.
module snoop_agent #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         CACHE_WB_REQ,
  input  logic [27:0]  CACHE_WB_ADDR,
  input  logic [127:0] CACHE_WB_DATA,
  output logic         CACHE_WB_DONE,
  input  logic         CACHE_MISS_REQ,
  input  logic [27:0]  CACHE_MISS_ADDR,
  output logic         CACHE_FILL_VALID,
  output logic         CACHE_FILL_HIT,
  output logic [127:0] CACHE_FILL_DATA,
  output logic         LOOKUP_EN,
  output logic [27:0]  LOOKUP_ADDR,
  input  logic         LOOKUP_HIT,
  input  logic [127:0] LOOKUP_DATA,
  output logic         SNOOP_UPDATE_EN,
  output logic [27:0]  SNOOP_UPDATE_ADDR,
  output logic [127:0] SNOOP_UPDATE_DATA,
  output logic [27:0]  OUT_ADDR_BUS,
  output logic [127:0] OUT_DATA_BUS,
  output logic         OUT_NEW_DATA_INTERUPT,
  output logic         OUT_REQUEST_DATA_INTERUPT,
  output logic         OUT_DATA_AVAILABLE,
  output logic         OUT_DATA_NOT_AVAILABLE,
  input  logic [27:0]  IN_BROADCAST_ADDR,
  input  logic [127:0] IN_BROADCAST_DATA,
  input  logic         IN_BROADCAST_INTERRUPT,
  input  logic         IN_PEER_REQUEST,
  input  logic         IN_DATA_FOUND,
  input  logic         IN_DATA_NOT_FOUND
);

  typedef enum logic [2:0] {S_IDLE, S_PUBLISH, S_MISS_WAIT, S_SERVE, S_FILL} state_t;

  state_t         r_state, w_next_state;
  logic           r_serve_ret;
  logic [27:0]    r_last_pub;
  logic           r_last_pub_vld;
  logic           w_cache_ok, w_timeout, w_verdict;

  logic           w_wb_done, w_fill_valid, w_fill_hit, w_lookup_en;
  logic [127:0]   w_fill_data, w_out_data;
  logic [27:0]    w_lookup_addr, w_out_addr;
  logic           w_new_data, w_req, w_avail, w_navail;

  // A held cache request is not re-sampled in the cycle its done/valid strobe is up.
  assign w_cache_ok = !CACHE_WB_DONE && !CACHE_FILL_VALID;
  assign w_verdict  = IN_DATA_FOUND || IN_DATA_NOT_FOUND || w_timeout;

`ifdef SNOOP_AGENT_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] r_to_cnt;

  assign w_timeout = (r_to_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Holds its value across a SERVE detour so the wait resumes where it paused.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                        r_to_cnt <= '0;
    else if (r_state == S_MISS_WAIT)  r_to_cnt <= r_to_cnt + 1'b1;
    else if (r_state != S_SERVE)      r_to_cnt <= '0;
  end
`else
  logic w_unused_timeout;
  assign w_timeout        = 1'b0;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state                   <= S_IDLE;
      r_serve_ret               <= 1'b0;
      CACHE_WB_DONE             <= 1'b0;
      CACHE_FILL_VALID          <= 1'b0;
      CACHE_FILL_HIT            <= 1'b0;
      CACHE_FILL_DATA           <= '0;
      LOOKUP_EN                 <= 1'b0;
      LOOKUP_ADDR               <= '0;
      OUT_ADDR_BUS              <= '0;
      OUT_DATA_BUS              <= '0;
      OUT_NEW_DATA_INTERUPT     <= 1'b0;
      OUT_REQUEST_DATA_INTERUPT <= 1'b0;
      OUT_DATA_AVAILABLE        <= 1'b0;
      OUT_DATA_NOT_AVAILABLE    <= 1'b0;
    end else begin
      r_state                   <= w_next_state;
      if (w_next_state == S_SERVE) r_serve_ret <= (r_state == S_MISS_WAIT);
      CACHE_WB_DONE             <= w_wb_done;
      CACHE_FILL_VALID          <= w_fill_valid;
      CACHE_FILL_HIT            <= w_fill_hit;
      CACHE_FILL_DATA           <= w_fill_data;
      LOOKUP_EN                 <= w_lookup_en;
      LOOKUP_ADDR               <= w_lookup_addr;
      OUT_ADDR_BUS              <= w_out_addr;
      OUT_DATA_BUS              <= w_out_data;
      OUT_NEW_DATA_INTERUPT     <= w_new_data;
      OUT_REQUEST_DATA_INTERUPT <= w_req;
      OUT_DATA_AVAILABLE        <= w_avail;
      OUT_DATA_NOT_AVAILABLE    <= w_navail;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (IN_PEER_REQUEST)                   w_next_state = S_SERVE;
        else if (w_cache_ok && CACHE_WB_REQ)   w_next_state = S_PUBLISH;
        else if (w_cache_ok && CACHE_MISS_REQ) w_next_state = S_MISS_WAIT;
      end
      S_PUBLISH:   w_next_state = S_IDLE;
      S_MISS_WAIT: begin
        if (w_verdict)            w_next_state = S_FILL;
        else if (IN_PEER_REQUEST) w_next_state = S_SERVE;
      end
      S_SERVE:     w_next_state = r_serve_ret ? S_MISS_WAIT : S_IDLE;
      S_FILL:      w_next_state = S_IDLE;
      default:     w_next_state = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; strobes default low, buses hold.
  always_comb begin
    w_wb_done     = 1'b0;
    w_fill_valid  = 1'b0;
    w_fill_hit    = CACHE_FILL_HIT;
    w_fill_data   = CACHE_FILL_DATA;
    w_lookup_en   = 1'b0;
    w_lookup_addr = LOOKUP_ADDR;
    w_out_addr    = OUT_ADDR_BUS;
    w_out_data    = OUT_DATA_BUS;
    w_new_data    = 1'b0;
    w_req         = OUT_REQUEST_DATA_INTERUPT;
    w_avail       = 1'b0;
    w_navail      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (IN_PEER_REQUEST) begin
          w_lookup_en   = 1'b1;
          w_lookup_addr = IN_BROADCAST_ADDR;
        end else if (w_cache_ok && CACHE_WB_REQ) begin
          w_out_addr = CACHE_WB_ADDR;
          w_out_data = CACHE_WB_DATA;
          w_new_data = 1'b1;
        end else if (w_cache_ok && CACHE_MISS_REQ) begin
          w_out_addr = CACHE_MISS_ADDR;
          w_req      = 1'b1;
        end
      end
      S_PUBLISH: w_wb_done = 1'b1;
      S_MISS_WAIT: begin
        if (w_verdict) begin
          w_req        = 1'b0;
          w_fill_valid = 1'b1;
          w_fill_hit   = IN_DATA_FOUND;
          w_fill_data  = IN_DATA_FOUND ? IN_BROADCAST_DATA : '0;
        end else if (IN_PEER_REQUEST) begin
          w_lookup_en   = 1'b1;
          w_lookup_addr = IN_BROADCAST_ADDR;
        end
      end
      S_SERVE: begin
        if (LOOKUP_HIT) begin
          w_avail    = 1'b1;
          w_out_data = LOOKUP_DATA;
        end else begin
          w_navail   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Broadcast path runs beside the FSM; a broadcast of our last publish is our own echo.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      SNOOP_UPDATE_EN   <= 1'b0;
      SNOOP_UPDATE_ADDR <= '0;
      SNOOP_UPDATE_DATA <= '0;
      r_last_pub        <= '0;
      r_last_pub_vld    <= 1'b0;
    end else begin
      SNOOP_UPDATE_EN <= 1'b0;
      if (IN_BROADCAST_INTERRUPT) begin
        if (r_last_pub_vld && (IN_BROADCAST_ADDR == r_last_pub)) begin
          r_last_pub_vld <= 1'b0;
        end else begin
          SNOOP_UPDATE_EN   <= 1'b1;
          SNOOP_UPDATE_ADDR <= IN_BROADCAST_ADDR;
          SNOOP_UPDATE_DATA <= IN_BROADCAST_DATA;
        end
      end
      if (r_state == S_PUBLISH) begin
        r_last_pub     <= OUT_ADDR_BUS;
        r_last_pub_vld <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_snoop_agent.sv
// Scoreboard bench for snoop_agent: driver tasks push expectations, a negedge monitor pops and compares.
module tb_snoop_agent;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         CACHE_WB_REQ = 1'b0;
  logic [27:0]  CACHE_WB_ADDR = '0;
  logic [127:0] CACHE_WB_DATA = '0;
  logic         CACHE_WB_DONE;
  logic         CACHE_MISS_REQ = 1'b0;
  logic [27:0]  CACHE_MISS_ADDR = '0;
  logic         CACHE_FILL_VALID, CACHE_FILL_HIT;
  logic [127:0] CACHE_FILL_DATA;
  logic         LOOKUP_EN;
  logic [27:0]  LOOKUP_ADDR;
  logic         LOOKUP_HIT = 1'b0;
  logic [127:0] LOOKUP_DATA = '0;
  logic         SNOOP_UPDATE_EN;
  logic [27:0]  SNOOP_UPDATE_ADDR;
  logic [127:0] SNOOP_UPDATE_DATA;
  logic [27:0]  OUT_ADDR_BUS;
  logic [127:0] OUT_DATA_BUS;
  logic         OUT_NEW_DATA_INTERUPT, OUT_REQUEST_DATA_INTERUPT;
  logic         OUT_DATA_AVAILABLE, OUT_DATA_NOT_AVAILABLE;
  logic [27:0]  IN_BROADCAST_ADDR = '0;
  logic [127:0] IN_BROADCAST_DATA = '0;
  logic         IN_BROADCAST_INTERRUPT = 1'b0;
  logic         IN_PEER_REQUEST = 1'b0;
  logic         IN_DATA_FOUND = 1'b0;
  logic         IN_DATA_NOT_FOUND = 1'b0;

  snoop_agent #(.TIMEOUT_CYCLES(8)) dut (
    .CLK(CLK), .RESET(RESET),
    .CACHE_WB_REQ(CACHE_WB_REQ), .CACHE_WB_ADDR(CACHE_WB_ADDR), .CACHE_WB_DATA(CACHE_WB_DATA),
    .CACHE_WB_DONE(CACHE_WB_DONE),
    .CACHE_MISS_REQ(CACHE_MISS_REQ), .CACHE_MISS_ADDR(CACHE_MISS_ADDR),
    .CACHE_FILL_VALID(CACHE_FILL_VALID), .CACHE_FILL_HIT(CACHE_FILL_HIT), .CACHE_FILL_DATA(CACHE_FILL_DATA),
    .LOOKUP_EN(LOOKUP_EN), .LOOKUP_ADDR(LOOKUP_ADDR), .LOOKUP_HIT(LOOKUP_HIT), .LOOKUP_DATA(LOOKUP_DATA),
    .SNOOP_UPDATE_EN(SNOOP_UPDATE_EN), .SNOOP_UPDATE_ADDR(SNOOP_UPDATE_ADDR), .SNOOP_UPDATE_DATA(SNOOP_UPDATE_DATA),
    .OUT_ADDR_BUS(OUT_ADDR_BUS), .OUT_DATA_BUS(OUT_DATA_BUS),
    .OUT_NEW_DATA_INTERUPT(OUT_NEW_DATA_INTERUPT), .OUT_REQUEST_DATA_INTERUPT(OUT_REQUEST_DATA_INTERUPT),
    .OUT_DATA_AVAILABLE(OUT_DATA_AVAILABLE), .OUT_DATA_NOT_AVAILABLE(OUT_DATA_NOT_AVAILABLE),
    .IN_BROADCAST_ADDR(IN_BROADCAST_ADDR), .IN_BROADCAST_DATA(IN_BROADCAST_DATA),
    .IN_BROADCAST_INTERRUPT(IN_BROADCAST_INTERRUPT), .IN_PEER_REQUEST(IN_PEER_REQUEST),
    .IN_DATA_FOUND(IN_DATA_FOUND), .IN_DATA_NOT_FOUND(IN_DATA_NOT_FOUND)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  int n_done_exp = 0;
  int n_done_seen = 0;

  // Expected-response queues, one per DUT output channel.
  logic [155:0] q_pub[$];
  logic [128:0] q_fill[$];
  logic [27:0]  q_look[$];
  logic [128:0] q_resp[$];
  logic [155:0] q_upd[$];

  // Reference state: the address of the agent's latest publication, if still valid.
  logic [27:0]  m_lp = '0;
  logic         m_lp_vld = 1'b0;

  logic [155:0] e156;
  logic [128:0] e129;
  logic [27:0]  e28;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic unexp(input string nm);
    n_checks++;
    n_errors++;
    $display("FAIL %s actual=strobe expected=none", nm);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always @(negedge CLK) begin
    if (!RESET) begin
      if (OUT_NEW_DATA_INTERUPT) begin
        if (q_pub.size() == 0) unexp("pub_strobe");
        else begin e156 = q_pub.pop_front(); chk("pub_bus", {OUT_ADDR_BUS, OUT_DATA_BUS}, e156); end
      end
      if (CACHE_WB_DONE) n_done_seen++;
      if (CACHE_FILL_VALID) begin
        if (q_fill.size() == 0) unexp("fill_strobe");
        else begin
          e129 = q_fill.pop_front();
          chk("fill", {CACHE_FILL_HIT, CACHE_FILL_HIT ? CACHE_FILL_DATA : 128'd0}, e129);
        end
      end
      if (LOOKUP_EN) begin
        if (q_look.size() == 0) unexp("lookup_strobe");
        else begin e28 = q_look.pop_front(); chk("lookup_addr", LOOKUP_ADDR, e28); end
      end
      if (OUT_DATA_AVAILABLE || OUT_DATA_NOT_AVAILABLE) begin
        if (q_resp.size() == 0) unexp("serve_strobe");
        else begin
          e129 = q_resp.pop_front();
          chk("serve_resp", {OUT_DATA_AVAILABLE, OUT_DATA_NOT_AVAILABLE, OUT_DATA_AVAILABLE ? OUT_DATA_BUS : 128'd0},
              {e129[128], !e129[128], e129[127:0]});
        end
      end
      if (SNOOP_UPDATE_EN) begin
        if (q_upd.size() == 0) unexp("update_strobe");
        else begin e156 = q_upd.pop_front(); chk("update", {SNOOP_UPDATE_ADDR, SNOOP_UPDATE_DATA}, e156); end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_pub(input logic [27:0] a, input logic [127:0] d);
    int k;
    q_pub.push_back({a, d});
    n_done_exp++;
    CACHE_WB_ADDR = a; CACHE_WB_DATA = d; CACHE_WB_REQ = 1'b1;
    k = 0;
    do begin step(); k++; end while (!CACHE_WB_DONE && k < 20);
    chk("pub_done_latency", k, 2);
    m_lp = a; m_lp_vld = 1'b1;
    step();  // request held through the done cycle's closing edge, like a registered cache
    CACHE_WB_REQ = 1'b0;
  endtask

  task automatic do_bcast(input logic [27:0] a, input logic [127:0] d);
    logic echo;
    echo = m_lp_vld && (a == m_lp);
    if (echo) m_lp_vld = 1'b0;
    else q_upd.push_back({a, d});
    IN_BROADCAST_ADDR = a; IN_BROADCAST_DATA = d; IN_BROADCAST_INTERRUPT = 1'b1;
    step();
    IN_BROADCAST_INTERRUPT = 1'b0;
    chk("bcast_update_en", SNOOP_UPDATE_EN, !echo);
  endtask

  task automatic do_serve(input logic [27:0] a, input logic hit, input logic [127:0] d, input logic req_lvl);
    q_look.push_back(a);
    q_resp.push_back({hit, hit ? d : 128'd0});
    LOOKUP_HIT = hit; LOOKUP_DATA = d;
    IN_BROADCAST_ADDR = a; IN_PEER_REQUEST = 1'b1;
    step();
    IN_PEER_REQUEST = 1'b0;
    chk("serve_lookup_en", LOOKUP_EN, 1);
    chk("serve_req_level1", OUT_REQUEST_DATA_INTERUPT, req_lvl);
    step();
    chk("serve_strobe_n2", OUT_DATA_AVAILABLE ^ OUT_DATA_NOT_AVAILABLE, 1);
    chk("serve_req_level2", OUT_REQUEST_DATA_INTERUPT, req_lvl);
  endtask

  // mode: 0 found, 1 not found, 2 both verdicts (found wins), 3 serve detour then not found,
  //       4 matching broadcast during wait then found
  task automatic do_miss(input logic [27:0] a, input int mode, input int gap, input logic [127:0] d);
    logic found;
    found = (mode == 0) || (mode == 2) || (mode == 4);
    CACHE_MISS_ADDR = a; CACHE_MISS_REQ = 1'b1;
    step();
    chk("miss_req_rise", OUT_REQUEST_DATA_INTERUPT, 1);
    chk("miss_addr_bus", OUT_ADDR_BUS, a);
    for (int i = 0; i < gap; i++) step();
    if (mode == 3) do_serve(28'($urandom), 1'($urandom), rnd128(), 1'b1);
    if (mode == 4) do_bcast(a, rnd128());
    chk("miss_req_held", OUT_REQUEST_DATA_INTERUPT, 1);
    q_fill.push_back({found, found ? d : 128'd0});
    IN_BROADCAST_DATA = d;
    IN_DATA_FOUND     = found;
    IN_DATA_NOT_FOUND = !found || (mode == 2);
    step();
    IN_DATA_FOUND = 1'b0; IN_DATA_NOT_FOUND = 1'b0;
    chk("fill_latency", CACHE_FILL_VALID, 1);
    chk("fill_req_drop", OUT_REQUEST_DATA_INTERUPT, 0);
    step();
    CACHE_MISS_REQ = 1'b0;
  endtask

  task automatic do_no_verdict(input logic [27:0] a);
    int k;
    CACHE_MISS_ADDR = a; CACHE_MISS_REQ = 1'b1;
    step();
    chk("nv_req_rise", OUT_REQUEST_DATA_INTERUPT, 1);
`ifdef SNOOP_AGENT_TIMEOUT_EN
    q_fill.push_back({1'b0, 128'd0});
    k = 0;
    do begin step(); k++; end while (!CACHE_FILL_VALID && k < 40);
    chk("timeout_latency", k, 8);
    chk("timeout_req_drop", OUT_REQUEST_DATA_INTERUPT, 0);
    step();
    CACHE_MISS_REQ = 1'b0;
`else
    k = 0;
    for (int i = 0; i < 100; i++) begin step(); if (CACHE_FILL_VALID) k++; end
    chk("pending_at_100_req", OUT_REQUEST_DATA_INTERUPT, 1);
    chk("pending_at_100_nofill", k, 0);
    q_fill.push_back({1'b0, 128'd0});
    IN_DATA_NOT_FOUND = 1'b1;
    step();
    IN_DATA_NOT_FOUND = 1'b0;
    chk("late_fill", CACHE_FILL_VALID, 1);
    step();
    CACHE_MISS_REQ = 1'b0;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    logic [27:0] pre_reset_pub;
    int op;
    RESET = 1'b1;
    #12;
    chk("reset_outputs", |{CACHE_WB_DONE, CACHE_FILL_VALID, CACHE_FILL_HIT, CACHE_FILL_DATA, LOOKUP_EN, LOOKUP_ADDR,
        SNOOP_UPDATE_EN, SNOOP_UPDATE_ADDR, SNOOP_UPDATE_DATA, OUT_ADDR_BUS, OUT_DATA_BUS, OUT_NEW_DATA_INTERUPT,
        OUT_REQUEST_DATA_INTERUPT, OUT_DATA_AVAILABLE, OUT_DATA_NOT_AVAILABLE}, 0);
    step();
    RESET = 1'b0;
    step();

    do_pub(28'h0000123, {16{8'hA5}});
    do_bcast(28'h0000123, rnd128());               // own echo, ignored
    do_bcast(28'h0000123, {16{8'h5A}});            // echo already consumed: real update
    do_miss(28'h00000F0, 0, 4, {8{16'h1234}});
    do_serve(28'h0000040, 1'b1, rnd128(), 1'b0);
    do_serve(28'h0000040, 1'b0, rnd128(), 1'b0);
    do_miss(28'h0000777, 3, 2, rnd128());
    do_miss(28'h0000888, 2, 1, rnd128());
    do_miss(28'h0000999, 4, 0, rnd128());
    do_no_verdict(28'h0000ABC);

    // Asynchronous reset while waiting on a miss.
    pre_reset_pub = 28'h0000321;
    do_pub(pre_reset_pub, rnd128());
    CACHE_MISS_ADDR = 28'h0000555; CACHE_MISS_REQ = 1'b1;
    step(); step();
    #2 RESET = 1'b1;
    #1;
    chk("async_reset_outputs", |{CACHE_WB_DONE, CACHE_FILL_VALID, CACHE_FILL_HIT, CACHE_FILL_DATA, LOOKUP_EN,
        LOOKUP_ADDR, SNOOP_UPDATE_EN, SNOOP_UPDATE_ADDR, SNOOP_UPDATE_DATA, OUT_ADDR_BUS, OUT_DATA_BUS,
        OUT_NEW_DATA_INTERUPT, OUT_REQUEST_DATA_INTERUPT, OUT_DATA_AVAILABLE, OUT_DATA_NOT_AVAILABLE}, 0);
    CACHE_MISS_REQ = 1'b0;
    m_lp_vld = 1'b0;
    step();
    RESET = 1'b0;
    step();
    do_bcast(pre_reset_pub, rnd128());             // last_pub cleared by reset: not an echo
    do_pub(28'h0000246, rnd128());

    for (int n = 0; n < 40; n++) begin
      op = int'($urandom_range(0, 5));
      case (op)
        0: do_pub(28'($urandom), rnd128());
        1: do_bcast(($urandom_range(0, 1) == 1 && m_lp_vld) ? m_lp : 28'($urandom), rnd128());
        2: do_serve(28'($urandom), 1'($urandom), rnd128(), 1'b0);
        default: do_miss(28'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 6)), rnd128());
      endcase
    end

    step(); step();
    chk("pub_queue_empty", q_pub.size(), 0);
    chk("fill_queue_empty", q_fill.size(), 0);
    chk("lookup_queue_empty", q_look.size(), 0);
    chk("resp_queue_empty", q_resp.size(), 0);
    chk("update_queue_empty", q_upd.size(), 0);
    chk("wb_done_count", n_done_seen, n_done_exp);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/snoop_agent.md
# snoop_agent

Per-cache coherence agent sitting between one PE's data cache and the shared two-port snoop controller; one instance per PE. It is the cache-side end of the snoop protocol. It publishes locally written blocks to the controller and requests missing blocks from the peer cache. It also answers peer data requests by probing the local cache and applies broadcast updates to the local cache.

## Interface
- `TIMEOUT_CYCLES`, default 64: cycles a miss request waits for a controller verdict before falling back to "not found" (active only with the timeout macro).
- `CLK` in 1: clock; everything is sampled on the rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `CACHE_WB_REQ` in 1: cache requests publication of block `CACHE_WB_ADDR`/`CACHE_WB_DATA`; held until `CACHE_WB_DONE`.
- `CACHE_WB_ADDR` in 28 / `CACHE_WB_DATA` in 128: block address (16-byte block) and data.
- `CACHE_WB_DONE` out 1: one-cycle publication-complete pulse.
- `CACHE_MISS_REQ` in 1 / `CACHE_MISS_ADDR` in 28: cache miss request, held until `CACHE_FILL_VALID`.
- `CACHE_FILL_VALID` out 1: one-cycle miss-resolution pulse.
- `CACHE_FILL_HIT` out 1: qualifies `CACHE_FILL_VALID`. 1 means `CACHE_FILL_DATA` holds the peer's block; 0 means the cache must go to memory.
- `CACHE_FILL_DATA` out 128: fill data.
- `LOOKUP_EN` out 1 / `LOOKUP_ADDR` out 28: local tag probe.
- `LOOKUP_HIT` in 1 / `LOOKUP_DATA` in 128: combinational probe result, valid in the same cycle as `LOOKUP_EN`.
- `SNOOP_UPDATE_EN` out 1 / `SNOOP_UPDATE_ADDR` out 28 / `SNOOP_UPDATE_DATA` out 128: one-cycle overwrite of the local copy, if present.
- `OUT_ADDR_BUS` out 28 / `OUT_DATA_BUS` out 128: to controller `CPU_n_INPUT_ADDR_BUS`/`CPU_n_INPUT_DATA_BUS`.
- `OUT_NEW_DATA_INTERUPT` out 1: publication strobe.
- `OUT_REQUEST_DATA_INTERUPT` out 1: miss request level.
- `OUT_DATA_AVAILABLE` out 1 / `OUT_DATA_NOT_AVAILABLE` out 1: serve response strobes.
- `IN_BROADCAST_ADDR` in 28 / `IN_BROADCAST_DATA` in 128 / `IN_BROADCAST_INTERRUPT` in 1: controller broadcast.
- `IN_PEER_REQUEST` in 1: controller asks this agent for block `IN_BROADCAST_ADDR`.
- `IN_DATA_FOUND` in 1 / `IN_DATA_NOT_FOUND` in 1: controller verdict for our pending miss. On found, the data is on `IN_BROADCAST_DATA`.

## Operation
- FSM states: IDLE, PUBLISH, MISS_WAIT, SERVE, FILL. The reset state is IDLE.
- All outputs are registered and reset to 0, including all buses.
- IDLE arbitration, highest priority first:
  - `IN_PEER_REQUEST`: latch `IN_BROADCAST_ADDR`, go to SERVE.
  - `CACHE_WB_REQ`: drive `OUT_ADDR_BUS`/`OUT_DATA_BUS`, pulse `OUT_NEW_DATA_INTERUPT`, go to PUBLISH.
  - `CACHE_MISS_REQ`: drive `OUT_ADDR_BUS`, raise `OUT_REQUEST_DATA_INTERUPT`, go to MISS_WAIT.
- PUBLISH: pulse `CACHE_WB_DONE`, record the published address as `last_pub`, then return to IDLE.
- MISS_WAIT:
  - `OUT_REQUEST_DATA_INTERUPT` stays high.
  - On `IN_DATA_FOUND`: capture `IN_BROADCAST_DATA`, set hit=1, go to FILL.
  - On `IN_DATA_NOT_FOUND`: set hit=0, go to FILL.
  - If both are asserted, FOUND wins.
  - An `IN_PEER_REQUEST` arriving in MISS_WAIT is served: take a SERVE detour, then return to MISS_WAIT with the request still high. This avoids deadlock when both PEs miss.
- FILL: drop `OUT_REQUEST_DATA_INTERUPT`, pulse `CACHE_FILL_VALID` with `CACHE_FILL_HIT`/`CACHE_FILL_DATA`, then return to IDLE.
- SERVE:
  - Assert `LOOKUP_EN` with the latched address.
  - Next cycle, drive `OUT_DATA_AVAILABLE`=1 with `OUT_DATA_BUS`=`LOOKUP_DATA` if `LOOKUP_HIT`, else pulse `OUT_DATA_NOT_AVAILABLE`.
  - Exactly one of the two strobes pulses per serve.
- Broadcast path (independent of the FSM, any state):
  - `IN_BROADCAST_INTERRUPT` with an address ≠ `last_pub` produces a one-cycle `SNOOP_UPDATE_*` the next cycle.
  - An address equal to `last_pub` is the agent's own echo: ignored, and `last_pub` is cleared to invalid.
- If a broadcast matches the pending miss address while in MISS_WAIT, the update is still issued; the fill proceeds normally.
- Reset mid-operation returns the FSM to IDLE, clears `last_pub` and the timeout counter, and drops all strobes. The cache is expected to re-issue its requests.

## Timing
- Publish: `CACHE_WB_REQ` sampled at edge N → `OUT_NEW_DATA_INTERUPT` high in cycle N+1 → `CACHE_WB_DONE` high in N+2.
- Miss: request sampled at N → `OUT_REQUEST_DATA_INTERUPT` high from N+1. Verdict sampled at edge M → `CACHE_FILL_VALID` high in M+1, with the request low from M+1.
- Serve: `IN_PEER_REQUEST` sampled at N → `LOOKUP_EN` in N+1 → response strobe in N+2.
- Broadcast to `SNOOP_UPDATE_EN`: 1 cycle.
- Back-to-back requests: the cache holds `*_REQ` until its done/valid strobe. The agent samples a new request no earlier than the cycle after that strobe.

## Configuration
- `SNOOP_AGENT_TIMEOUT_EN` defined:
  - A counter clears on entry to MISS_WAIT and increments each MISS_WAIT cycle, pausing during SERVE detours.
  - When it reaches `TIMEOUT_CYCLES-1` without a verdict, go to FILL with hit=0.
- Undefined: no counter; MISS_WAIT waits indefinitely.

## Test plan
- Publish of addr 0x0000123, data 0xA5…A5 → `OUT_NEW_DATA_INTERUPT` for 1 cycle with those buses, `CACHE_WB_DONE` one cycle later. An echo broadcast of 0x0000123 yields no `SNOOP_UPDATE_EN`.
- Miss on 0x00000F0 with `IN_DATA_FOUND` 5 cycles later and broadcast data 0x1234…→ `CACHE_FILL_VALID`=1, `CACHE_FILL_HIT`=1, `CACHE_FILL_DATA`=0x1234…, request deasserted the same cycle.
- Peer request for 0x0000040: with `LOOKUP_HIT`=1 → `OUT_DATA_AVAILABLE` plus data at N+2. With `LOOKUP_HIT`=0 → `OUT_DATA_NOT_AVAILABLE` only.
- `IN_PEER_REQUEST` during MISS_WAIT → serve completes while `OUT_REQUEST_DATA_INTERUPT` stays 1, then the later `IN_DATA_NOT_FOUND` gives a fill with hit=0.
- With `SNOOP_AGENT_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, a miss with no verdict → fill with hit=0 exactly 8 cycles after request assertion. Without the macro, still pending at cycle 100.
- `RESET` asserted while in MISS_WAIT → all outputs 0 immediately (asynchronous). After release, the FSM is in IDLE and a new publish works.
